coin_input_conditioner: RTL and testbench

- Upstream front-end for the credit FSM.
- Turns the raw coin and accept push-button inputs into clean, synchronised, debounced levels and single-cycle rising-edge pulses.
- Coin pulses get a post-acceptance lockout so one mechanical insertion can never yield two credits.
- Keeps a saturating count of accepted coins for diagnostics.

---
 rtl/credit_pkg.sv | 23 ++
 rtl/debounce_channel.sv | 56 +++++
 rtl/coin_input_conditioner.sv | 138 +++++++++++++
 tb/tb_coin_input_conditioner.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_pkg.sv
// rtl/credit_pkg.sv - shared types and timing defaults for the coin/credit front-end
//
// Purpose : lockout FSM state type, coin counter width, default timing
//           constants (100 MHz clock) and a saturating-increment helper.
// Ports   : none (package).
package credit_pkg;

    typedef enum logic {
        READY  = 1'b0,
        LOCKED = 1'b1
    } lockout_state_t;

    localparam int COUNT_W = 8;

    localparam int DEBOUNCE_CYCLES_DEF = 1000000;    // 10 ms
    localparam int LOCKOUT_CYCLES_DEF  = 5000000;    // 50 ms
    localparam int STUCK_CYCLES_DEF    = 200000000;  // 2 s

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - 2-flop synchroniser, debouncer and rise detector for one input
//
// Purpose : synchronise a raw switch, qualify a level change after
//           DEBOUNCE_CYCLES consecutive differing enabled cycles.
// Ports   : clk, rst_n (async, active-low), ena (freeze when low),
//           raw (unsynchronised input), level (registered debounced level),
//           rise_d (combinational: level rises on the coming edge; the
//           parent registers it so the pulse lines up with level).
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw,
    output logic level,
    output logic rise_d
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;
    logic          differs;
    logic          qualified;

    assign differs   = (sync_q2 != level);
    assign qualified = ena && differs && (cnt == CNT_LAST);
    assign rise_d    = qualified && !level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            // Synchroniser keeps sampling even while frozen.
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (ena) begin
                if (!differs) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/coin_input_conditioner.sv
// rtl/coin_input_conditioner.sv - coin/accept input conditioning with coin lockout and count
//
// Purpose : debounced levels and rise pulses for coin and accept inputs,
//           post-acceptance coin lockout, saturating accepted-coin count.
// Option  : define COIN_STUCK_DET_EN to enable the stuck-coin detector;
//           otherwise coin_stuck is tied low.
// Ports   : clk, rst_n (async, active-low), ena (global enable),
//           coin_raw, accept_raw (raw switches), count_clr (sync clear),
//           coin_level, accept_level, coin_pulse, accept_pulse,
//           coin_reject, coin_count[7:0], coin_stuck (all registered).
module coin_input_conditioner
    import credit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               coin_raw,
    input  logic               accept_raw,
    input  logic               count_clr,
    output logic               coin_level,
    output logic               accept_level,
    output logic               coin_pulse,
    output logic               accept_pulse,
    output logic               coin_reject,
    output logic [COUNT_W-1:0] coin_count,
    output logic               coin_stuck
);

    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

    logic           coin_rise;
    logic           accept_rise;
    logic           coin_blocked;
    logic           coin_accept;
    lockout_state_t lock_state;
    logic [LW-1:0]  lock_cnt;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .raw    (coin_raw),
        .level  (coin_level),
        .rise_d (coin_rise)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_accept (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .raw    (accept_raw),
        .level  (accept_level),
        .rise_d (accept_rise)
    );

    // A rise is turned into a reject rather than a credit while the
    // lockout window is open or the coin path is flagged stuck.
    assign coin_blocked = (lock_state == LOCKED) || coin_stuck;
    assign coin_accept  = coin_rise && !coin_blocked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state   <= READY;
            lock_cnt     <= '0;
            coin_pulse   <= 1'b0;
            accept_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            coin_count   <= '0;
        end else begin
            coin_pulse   <= coin_accept;
            coin_reject  <= coin_rise && coin_blocked;
            accept_pulse <= accept_rise;

            case (lock_state)
                READY: begin
                    if (coin_accept) begin
                        lock_state <= LOCKED;
                        lock_cnt   <= LOCK_LOAD;
                    end
                end
                LOCKED: begin
                    if (ena) begin
                        if (lock_cnt == '0) begin
                            lock_state <= READY;
                        end else begin
                            lock_cnt <= lock_cnt - 1'b1;
                        end
                    end
                end
                default: lock_state <= READY;
            endcase

            if (count_clr) begin
                coin_count <= '0;
            end else if (coin_accept) begin
                coin_count <= sat_inc(coin_count);
            end
        end
    end

`ifdef COIN_STUCK_DET_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

    logic [SW-1:0] stuck_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_cnt  <= '0;
            coin_stuck <= 1'b0;
        end else begin
            if (!coin_level) begin
                stuck_cnt <= '0;
            end else if (ena && !coin_stuck) begin
                if (stuck_cnt == STUCK_LAST) begin
                    coin_stuck <= 1'b1;
                end else begin
                    stuck_cnt <= stuck_cnt + 1'b1;
                end
            end
            // Only an operator accept with the coin path idle releases the flag.
            if (accept_pulse && !coin_level) begin
                coin_stuck <= 1'b0;
            end
        end
    end
`else
    // Constant-false tie-off; referencing the parameter keeps one interface
    // for both builds.
    assign coin_stuck = (STUCK_CYCLES < 0);
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// tb/tb_coin_input_conditioner.sv - scoreboard testbench for coin_input_conditioner
module tb_coin_input_conditioner;

    localparam int D = 4;
    localparam int L = 10;
    localparam int S = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       coin_raw = 1'b0;
    logic       accept_raw = 1'b0;
    logic       count_clr = 1'b0;
    logic       coin_level, accept_level, coin_pulse, accept_pulse;
    logic       coin_reject, coin_stuck;
    logic [7:0] coin_count;

    always #5 clk = ~clk;

    coin_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (L),
        .STUCK_CYCLES   (S)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .coin_raw     (coin_raw),
        .accept_raw   (accept_raw),
        .count_clr    (count_clr),
        .coin_level   (coin_level),
        .accept_level (accept_level),
        .coin_pulse   (coin_pulse),
        .accept_pulse (accept_pulse),
        .coin_reject  (coin_reject),
        .coin_count   (coin_count),
        .coin_stuck   (coin_stuck)
    );

    logic [13:0] dut_vec;
    assign dut_vec = {coin_level, accept_level, coin_pulse, accept_pulse,
                      coin_reject, coin_stuck, coin_count};

    int          errors = 0;
    int          checks = 0;
    int unsigned edge_no = 0;
    int          rejects_seen = 0;

    typedef struct {
        int unsigned e;
        logic [13:0] v;
    } ev_t;
    ev_t sb[$];
    ev_t mon_ev;
    logic [13:0] mon_prev = '0;

    // Reference model: raw delayed by two samples, level flips after D
    // consecutive enabled samples that disagree with it, lockout measured
    // as L enabled edges following an accepted coin.
    bit          m_s1[2], m_s2[2], m_lvl[2];
    int          m_run[2];
    int          m_lock, m_cnt, m_high;
    bit          m_stuck, m_cp, m_ap, m_rj;
    logic [13:0] m_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
        end
        m_lock = 0; m_cnt = 0; m_high = 0;
        m_stuck = 0; m_cp = 0; m_ap = 0; m_rj = 0;
        m_prev = '0;
    endtask

    task automatic model_edge();
        bit raw[2];
        bit rise[2];
        bit sync, locked, lvl_pre_c, ap_pre;
        logic [13:0] mv;
        raw[0] = coin_raw;
        raw[1] = accept_raw;
        lvl_pre_c = m_lvl[0];
        ap_pre = m_ap;
        for (int ch = 0; ch < 2; ch++) begin
            rise[ch] = 0;
            sync = m_s2[ch];
            m_s2[ch] = m_s1[ch];
            m_s1[ch] = raw[ch];
            if (ena) begin
                if (sync != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == D) begin
                        m_lvl[ch] = sync;
                        m_run[ch] = 0;
                        rise[ch] = sync;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
        end
        locked = (m_lock > 0) || m_stuck;
        m_cp = rise[0] && !locked;
        m_rj = rise[0] && locked;
        m_ap = rise[1];
        if (ena && m_lock > 0) m_lock--;
        if (m_cp) m_lock = L;
        if (count_clr) m_cnt = 0;
        else if (m_cp && m_cnt < 255) m_cnt++;
`ifdef COIN_STUCK_DET_EN
        if (!lvl_pre_c) m_high = 0;
        else if (ena && !m_stuck) begin
            m_high++;
            if (m_high >= S) m_stuck = 1;
        end
        if (ap_pre && !lvl_pre_c) m_stuck = 0;
`endif
        mv = {m_lvl[0], m_lvl[1], m_cp, m_ap, m_rj, m_stuck, 8'(m_cnt)};
        if (mv != m_prev || m_cp || m_ap || m_rj) sb.push_back('{edge_no, mv});
        m_prev = mv;
    endtask

    task automatic step(input bit c, input bit a, input bit e = 1'b1, input bit clr = 1'b0);
        coin_raw = c;
        accept_raw = a;
        ena = e;
        count_clr = clr;
        @(posedge clk);
        edge_no++;
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic hold(input bit c, input bit a, input int n);
        repeat (n) step(c, a);
    endtask

    // Monitor: pops one expected event whenever the DUT outputs change or pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev = '0;
        end else begin
            if (dut_vec != mon_prev || coin_pulse || accept_pulse || coin_reject) begin
                if (coin_reject) rejects_seen++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected edge=%0d actual=%h required=none", edge_no, dut_vec);
                end else begin
                    mon_ev = sb.pop_front();
                    if (mon_ev.e != edge_no || mon_ev.v !== dut_vec) begin
                        errors++;
                        $display("FAIL sb_event actual edge=%0d vec=%h required edge=%0d vec=%h",
                                 edge_no, dut_vec, mon_ev.e, mon_ev.v);
                    end
                end
            end
            mon_prev = dut_vec;
        end
    end

    initial begin
        int rj0;
        bit rc, ra;
        model_reset();
        repeat (3) step(0, 0);
        check("reset_state", 32'(dut_vec), 32'h0);
        #2 rst_n = 1'b1;

        // Clean step: level and pulse appear after the sixth sampling edge.
        repeat (5) step(1, 0);
        check("step_level_early", 32'(coin_level), 32'h0);
        step(1, 0);
        check("step_pulse", 32'(coin_pulse), 32'h1);
        check("step_level", 32'(coin_level), 32'h1);
        hold(1, 0, 3);
        hold(0, 0, 20);
        check("step_count", 32'(coin_count), 32'd1);

        // Bounce then settle.
        step(1, 0); step(0, 0); step(1, 0); step(0, 0);
        hold(1, 0, 10);
        hold(0, 0, 20);
        check("bounce_count", 32'(coin_count), 32'd2);

        // Second press lands inside the lockout window.
        rj0 = rejects_seen;
        hold(1, 0, 5);
        hold(0, 0, 5);
        hold(1, 0, 8);
        hold(0, 0, 25);
        check("lockout_rejects", 32'(rejects_seen - rj0), 32'd1);
        check("lockout_count", 32'(coin_count), 32'd3);
        hold(1, 0, 8);
        hold(0, 0, 20);
        check("post_lockout_count", 32'(coin_count), 32'd4);

        // Saturation, then clear coincident with a pulse.
        repeat (260) begin
            hold(1, 0, 6);
            hold(0, 0, 16);
        end
        check("sat_count", 32'(coin_count), 32'd255);
        repeat (3) step(1, 0);
        repeat (5) step(1, 0, 1, 1);
        hold(1, 0, 2);
        hold(0, 0, 16);
        check("clr_count", 32'(coin_count), 32'd0);

        // Simultaneous coin and accept, then async reset mid-qualification.
        hold(1, 1, 8);
        hold(0, 1, 16);
        check("both_levels", 32'({coin_level, accept_level, coin_count}), 32'h101);
        step(1, 1);
        step(1, 1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_async", 32'(dut_vec), 32'h0);
        step(1, 1);
        step(1, 1);
        #2 rst_n = 1'b1;
        hold(1, 1, 8);
        hold(0, 0, 20);

        // Freeze after two qualifying counts.
        repeat (4) step(1, 0);
        repeat (10) step(1, 0, 0);
        step(1, 0, 1);
        check("ena_level_early", 32'(coin_level), 32'h0);
        step(1, 0, 1);
        check("ena_resume", 32'({coin_level, coin_pulse}), 32'h3);
        hold(1, 0, 4);
        hold(0, 0, 20);

`ifdef COIN_STUCK_DET_EN
        hold(1, 0, 30);
        check("stuck_set", 32'(coin_stuck), 32'h1);
        hold(0, 0, 15);
        hold(1, 0, 8);
        hold(0, 0, 15);
        hold(0, 1, 8);
        hold(0, 0, 10);
        check("stuck_clear", 32'(coin_stuck), 32'h0);
`endif

        // Random traffic against the model.
        rc = 0;
        ra = 0;
        repeat (2000) begin
            if ($urandom_range(0, 4) == 0) rc = ~rc;
            if ($urandom_range(0, 7) == 0) ra = ~ra;
            step(rc, ra, ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
        end
        repeat (30) step(0, 0);
        #6;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
